dff_pipe: RTL

DFF_PIPE -- requirements
Module: dff_pipe

---
 rtl/dff_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dff_pipe.sv
// Elastic register pipeline of DEPTH stages with valid/ready handshake and bubble collapse.
// Optional occupancy counter port `occ` is built only when DFF_PIPE_OCC_EN is defined.
module dff_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] d,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q
`ifdef DFF_PIPE_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] mv_s;
  logic [DEPTH-1:0] load_s;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic             accept_s;

  // Move chain: a stage advances when its successor is empty or itself advancing.
  always_comb begin : p_move
    logic ok_v;
    logic m_v;
    mv_s = '0;
    ok_v = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      m_v     = v_q[k] & ok_v;
      mv_s[k] = m_v;
      ok_v    = ~v_q[k] | m_v;
    end
  end

  assign in_ready = ~clr & (~v_q[0] | mv_s[0]);
  assign accept_s = in_valid & in_ready;

  // Stage k loads from the input (k = 0) or from the stage behind it.
  always_comb begin
    load_s    = '0;
    load_s[0] = accept_s;
    for (int k = 1; k < DEPTH; k++) begin
      load_s[k] = mv_s[k-1];
    end
  end

  // Next-state for valid flags and data; clr drops all valids but leaves data alone.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    if (clr) begin
      v_d = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (load_s[k]) begin
          v_d[k] = 1'b1;
        end else if (mv_s[k]) begin
          v_d[k] = 1'b0;
        end else begin
          v_d[k] = v_q[k];
        end
      end
      if (load_s[0]) begin
        data_d[0] = d;
      end else begin
        data_d[0] = data_q[0];
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (load_s[k]) begin
          data_d[k] = data_q[k-1];
        end else begin
          data_d[k] = data_q[k];
        end
      end
    end
  end

  // Stage registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      v_q <= v_d;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= data_d[k];
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign q         = data_q[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             hs_s;

  assign hs_s = v_q[DEPTH-1] & out_ready;

  // Occupancy next-state: track accepts against output handshakes.
  always_comb begin
    occ_d = occ_q;
    if (clr) begin
      occ_d = '0;
    end else begin
      case ({accept_s, hs_s})
        2'b10:   occ_d = occ_q + OCC_W'(1);
        2'b01:   occ_d = occ_q - OCC_W'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;
`endif

endmodule
